// File: rtl/dmem_demux_if.sv
// Bus bundle for dmem_demux: core request/response side plus two target ports.
interface dmem_demux_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        t0_valid;
    logic        t0_ready;
    logic        t0_we;
    logic [31:0] t0_addr;
    logic [31:0] t0_wdata;
    logic [3:0]  t0_be;
    logic        t0_rvalid;
    logic [31:0] t0_rdata;

    logic        t1_valid;
    logic        t1_ready;
    logic        t1_we;
    logic [31:0] t1_addr;
    logic [31:0] t1_wdata;
    logic [3:0]  t1_be;
    logic        t1_rvalid;
    logic [31:0] t1_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output t0_valid, t0_we, t0_addr, t0_wdata, t0_be,
        input  t0_ready, t0_rvalid, t0_rdata,
        output t1_valid, t1_we, t1_addr, t1_wdata, t1_be,
        input  t1_ready, t1_rvalid, t1_rdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  t0_valid, t0_we, t0_addr, t0_wdata, t0_be,
        output t0_ready, t0_rvalid, t0_rdata,
        input  t1_valid, t1_we, t1_addr, t1_wdata, t1_be,
        output t1_ready, t1_rvalid, t1_rdata
    );
endinterface

// File: rtl/dmem_demux.sv
// Routes MEM-stage loads/stores to data RAM (port 0) or MMIO (port 1).
// Define DMEM_DEMUX_TIMEOUT_EN to build the hung-target watchdog.
module dmem_demux #(
    parameter logic [3:0]  PORT0_NIB = 4'h0,
    parameter logic [3:0]  PORT1_NIB = 4'h1,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_demux_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic        ready_q;
    logic        resp_valid_q;
    logic        err_q;
    logic        err_n;
    logic [31:0] rdata_q;
    logic [31:0] rdata_n;
    logic        we_q;
    logic        port_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic        accept;
    logic        hit0;
    logic        hit1;
    logic        sel_ready;
    logic        sel_rvalid;
    logic [31:0] sel_rdata;
    logic        timeout;

    assign accept = bus.req_valid && ready_q;
    assign hit0   = (bus.req_addr[31:28] == PORT0_NIB);
    assign hit1   = (bus.req_addr[31:28] == PORT1_NIB);

    // Only the captured port is ever looked at; the other one is noise.
    assign sel_ready  = port_q ? bus.t1_ready  : bus.t0_ready;
    assign sel_rvalid = port_q ? bus.t1_rvalid : bus.t0_rvalid;
    assign sel_rdata  = port_q ? bus.t1_rdata  : bus.t0_rdata;

`ifdef DMEM_DEMUX_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wd_q;
    logic       busy;

    assign busy    = (state == REQ) || (state == WAIT);
    assign timeout = busy && (wd_q >= WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (state == IDLE) begin
            wd_q <= '0;
        end else if (busy && (wd_q != 8'hFF)) begin
            wd_q <= wd_q + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        rdata_n = rdata_q;
        err_n   = err_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    rdata_n = '0;
                    err_n   = !(hit0 || hit1);
                    state_n = (hit0 || hit1) ? REQ : RESP;
                end
            end
            REQ: begin
                if (sel_ready) begin
                    if (we_q) begin
                        state_n = RESP;
                    end else if (sel_rvalid) begin
                        state_n = RESP;
                        rdata_n = sel_rdata;
                    end else begin
                        state_n = WAIT;
                    end
                end else if (timeout) begin
                    state_n = RESP;
                    err_n   = 1'b1;
                end
            end
            WAIT: begin
                if (sel_rvalid) begin
                    state_n = RESP;
                    rdata_n = sel_rdata;
                end else if (timeout) begin
                    state_n = RESP;
                    err_n   = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            we_q         <= 1'b0;
            port_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
        end else begin
            state        <= state_n;
            ready_q      <= (state_n == IDLE);
            resp_valid_q <= (state_n == RESP);
            rdata_q      <= rdata_n;
            err_q        <= err_n;
            if (accept) begin
                we_q    <= bus.req_we;
                port_q  <= !hit0;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
            end
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    assign bus.t0_valid = (state == REQ) && !port_q;
    assign bus.t0_we    = we_q;
    assign bus.t0_addr  = addr_q;
    assign bus.t0_wdata = wdata_q;
    assign bus.t0_be    = be_q;

    assign bus.t1_valid = (state == REQ) && port_q;
    assign bus.t1_we    = we_q;
    assign bus.t1_addr  = addr_q;
    assign bus.t1_wdata = wdata_q;
    assign bus.t1_be    = be_q;
endmodule

// File: tb/tb_dmem_demux.sv
// Bench for dmem_demux: directed cases plus random transactions
// checked against a transaction-level timing/data model.
module tb_dmem_demux;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    dmem_demux_if bus ();

    dmem_demux #(
        .PORT0_NIB(4'h0),
        .PORT1_NIB(4'h1),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One transaction; the target answers with ready at cycle 1+rdy
    // and (loads) rvalid rv cycles later, counted from acceptance.
    task automatic run_txn(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input int rdy, input int rv,
                           input logic [31:0] tdata, output int acc);
        int          n;
        logic [3:0]  nib;
        logic        hit;
        logic        port;
        int          ev_r;
        int          ev;
        int          done;
        int          vend;
        logic [31:0] e_rd;
        logic        e_err;
        logic        exp_v;
`ifdef DMEM_DEMUX_TIMEOUT_EN
        int          dl;
`endif
        n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        chk1("req_ready_wait", bus.req_ready, 1'b1);
        acc = cyc;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;

        nib  = addr[31:28];
        hit  = (nib == 4'h0) || (nib == 4'h1);
        port = (nib != 4'h0);
        ev_r = 1 + rdy;
        ev   = we ? ev_r : ev_r + rv;
        if (!hit) begin
            done  = 1;
            vend  = 0;
            e_rd  = '0;
            e_err = 1'b1;
        end else begin
            done  = ev + 1;
            vend  = ev_r;
            e_rd  = we ? 32'h0 : tdata;
            e_err = 1'b0;
`ifdef DMEM_DEMUX_TIMEOUT_EN
            dl = (!we && ev_r == TO) ? TO + 1 : TO;
            if (vend > TO) vend = TO;
            if (ev > dl) begin
                done  = dl + 1;
                e_rd  = '0;
                e_err = 1'b1;
            end
`endif
        end

        for (int k = 1; k <= done + 1; k++) begin
            tick();
            exp_v = hit && (k <= vend);
            chk1("t0_valid", bus.t0_valid, exp_v && !port);
            chk1("t1_valid", bus.t1_valid, exp_v && port);
            if (exp_v) begin
                chk1("t_we", port ? bus.t1_we : bus.t0_we, we);
                chk32("t_addr", port ? bus.t1_addr : bus.t0_addr, addr);
                chk32("t_wdata", port ? bus.t1_wdata : bus.t0_wdata, wdata);
                chk32("t_be", 32'(port ? bus.t1_be : bus.t0_be), 32'(be));
            end
            chk1("resp_valid", bus.resp_valid, k == done);
            if (k == done) begin
                chk32("resp_rdata", bus.resp_rdata, e_rd);
                chk1("resp_err", bus.resp_err, e_err);
            end
            chk1("req_ready", bus.req_ready, k == done + 1);

            bus.t0_ready  = 1'($urandom_range(0, 1));
            bus.t0_rvalid = 1'($urandom_range(0, 1));
            bus.t0_rdata  = $urandom;
            bus.t1_ready  = 1'($urandom_range(0, 1));
            bus.t1_rvalid = 1'($urandom_range(0, 1));
            bus.t1_rdata  = $urandom;
            if (hit && !port) begin
                bus.t0_ready  = (k == ev_r);
                bus.t0_rvalid = !we && (k == ev);
                if (k == ev) bus.t0_rdata = tdata;
            end else if (hit) begin
                bus.t1_ready  = (k == ev_r);
                bus.t1_rvalid = !we && (k == ev);
                if (k == ev) bus.t1_rdata = tdata;
            end
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic quiet_targets();
        bus.t0_ready  = 1'b0;
        bus.t0_rvalid = 1'b0;
        bus.t0_rdata  = '0;
        bus.t1_ready  = 1'b0;
        bus.t1_rvalid = 1'b0;
        bus.t1_rdata  = '0;
    endtask

    initial begin
        int a0;
        int a1;
        int a2;
        int a3;
        int r;
        logic [3:0] nib;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        quiet_targets();

        tick();
        tick();
        chk1("rst_req_ready", bus.req_ready, 1'b0);
        chk1("rst_resp_valid", bus.resp_valid, 1'b0);
        chk32("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk1("rst_resp_err", bus.resp_err, 1'b0);
        chk1("rst_t0_valid", bus.t0_valid, 1'b0);
        chk1("rst_t1_valid", bus.t1_valid, 1'b0);
        chk32("rst_t0_addr", bus.t0_addr, 32'h0);
        chk32("rst_t1_wdata", bus.t1_wdata, 32'h0);
        rst_n = 1'b1;
        chk1("rel_req_ready_pre", bus.req_ready, 1'b0);
        tick();
        chk1("rel_req_ready_post", bus.req_ready, 1'b1);

        run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0, a0);
        run_txn(1'b0, 32'h1000_0004, 32'h0, 4'hF, 3, 2, 32'h1234_5678, a0);
        run_txn(1'b0, 32'h2000_0000, 32'h0, 4'hF, 0, 0, 32'h5555_AAAA, a0);

        run_txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 0, 32'hA000_0001, a0);
        run_txn(1'b0, 32'h0000_0104, 32'h0, 4'h3, 0, 0, 32'hA000_0002, a1);
        run_txn(1'b0, 32'h0000_0108, 32'h0, 4'hC, 0, 0, 32'hA000_0003, a2);
        run_txn(1'b0, 32'h0000_010C, 32'h0, 4'h1, 0, 0, 32'hA000_0004, a3);
        chk32("b2b_gap1", 32'(a1 - a0), 32'd3);
        chk32("b2b_gap2", 32'(a2 - a1), 32'd3);
        chk32("b2b_gap3", 32'(a3 - a2), 32'd3);

        // Reset pulse while a load waits for its data.
        quiet_targets();
        tick();
        chk1("wr_ready", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h1000_0020;
        tick();
        bus.req_valid = 1'b0;
        bus.t1_ready  = 1'b1;
        tick();
        bus.t1_ready = 1'b0;
        chk1("wr_t1_valid_wait", bus.t1_valid, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("ar_req_ready", bus.req_ready, 1'b0);
        chk1("ar_resp_valid", bus.resp_valid, 1'b0);
        chk32("ar_resp_rdata", bus.resp_rdata, 32'h0);
        chk1("ar_t1_valid", bus.t1_valid, 1'b0);
        chk32("ar_t1_addr", bus.t1_addr, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        bus.t1_rvalid = 1'b1;
        bus.t1_rdata  = 32'hBAD0_BAD0;
        chk1("ar_rel_ready_pre", bus.req_ready, 1'b0);
        tick();
        chk1("ar_rel_ready_post", bus.req_ready, 1'b1);
        chk1("ar_no_resp1", bus.resp_valid, 1'b0);
        bus.t1_rvalid = 1'b0;
        tick();
        chk1("ar_no_resp2", bus.resp_valid, 1'b0);

        // Port 0 never ready: watchdog error, or a long wait without it.
        run_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, 20, 0, 32'hCAFE_F00D, a0);
        quiet_targets();
        bus.t0_rvalid = 1'b1;
        bus.t0_rdata  = 32'h7777_7777;
        tick();
        bus.t0_rvalid = 1'b0;
        chk1("late_rvalid_1", bus.resp_valid, 1'b0);
        tick();
        chk1("late_rvalid_2", bus.resp_valid, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int rdy;
            int rv;
            r   = $urandom_range(0, 3);
            nib = (r < 2) ? 4'(r) : 4'($urandom_range(2, 15));
            rdy = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 10)
                                              : $urandom_range(0, 3);
            rv  = $urandom_range(0, 3);
            run_txn(1'($urandom_range(0, 1)), {nib, 28'($urandom)},
                    $urandom, 4'($urandom_range(0, 15)), rdy, rv,
                    $urandom, a0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_demux.md
# dmem_demux

Data-memory request demultiplexer for the MIPS32 core. It takes the single load/store request stream from the MEM stage and routes it to one of two targets: port 0 (data RAM) or port 1 (memory-mapped I/O). The target is chosen by the upper address nibble. The block then returns that target's read data and completion to the core. It holds one outstanding transaction, and it flags unmapped addresses and, optionally, hung targets as bus errors.

## Interface
- `PORT0_NIB`, default 4'h0: value of `req_addr[31:28]` that selects port 0.
- `PORT1_NIB`, default 4'h1: value of `req_addr[31:28]` that selects port 1.
- `TIMEOUT`, default 255: watchdog limit in cycles. Range 1..255.
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: the core presents a request.
- `req_ready` out 1: the block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `req_be` in 4: byte enables.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: load data.
- `resp_err` out 1: bus error, qualified by `resp_valid`.
- `t0_valid`, `t1_valid` out 1 each: request to the target.
- `t0_ready`, `t1_ready` in 1 each: target accepts the request.
- `t0_we`, `t1_we` out 1 each: store/load to the target.
- `t0_addr`, `t1_addr` out 32 each: address to the target.
- `t0_wdata`, `t1_wdata` out 32 each: store data to the target.
- `t0_be`, `t1_be` out 4 each: byte enables to the target.
- `t0_rvalid`, `t1_rvalid` in 1 each: load data valid from the target.
- `t0_rdata`, `t1_rdata` in 32 each: load data from the target.

## Operation
- FSM states and transitions:
  - **IDLE**: go to REQ when the decode hits a port; go to RESP with an error when the decode misses.
  - **REQ**: go to RESP for a store; go to WAIT or RESP for a load.
  - **WAIT**: go to RESP.
  - **RESP**: go to IDLE.
- Acceptance: a request is accepted when `req_valid` and `req_ready` are both high.
  - On acceptance, `req_we`, `req_addr`, `req_wdata`, `req_be` and the decoded port are captured into internal registers.
  - All `tX_*` request outputs drive from those registers, never combinationally from the `req_*` inputs.
- Decode:
  - `req_addr[31:28]` equal to `PORT0_NIB` selects port 0.
  - Equal to `PORT1_NIB` selects port 1.
  - If both parameters are equal, port 0 wins.
  - Any other nibble is a decode miss: no target is touched, and the block goes straight to RESP with `resp_err=1` and `resp_rdata=0`.
- REQ state:
  - Only the selected `tX_valid` is high. The non-selected port sees `valid=0`, and its other outputs are don't-care.
  - `tX_valid` and all its fields stay stable until `tX_ready` is high.
  - Store: `tX_ready` moves the FSM to RESP with `resp_err=0` and `resp_rdata=0`.
  - Load with `tX_ready` and `tX_rvalid` high in the same cycle: the data is captured and the FSM moves to RESP.
  - Load with `tX_ready` but no `tX_rvalid`: the FSM moves to WAIT, and `tX_valid` drops.
- WAIT state: `tX_rvalid` captures `tX_rdata` and the FSM moves to RESP. `rvalid` from the non-selected port is ignored in every state.
- RESP state:
  - `resp_valid=1` for exactly one cycle, carrying the registered `resp_rdata`/`resp_err`.
  - The FSM returns to IDLE.
  - The core cannot stall the response.
- Unaligned or partial accesses are passed through unchanged. Byte lane handling belongs to the target.

## Timing
- Reset values: `req_ready=0`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, all `tX_valid=0`, all `tX_*` fields 0, FSM in IDLE, watchdog 0.
- `req_ready` is registered: it is 1 exactly when the FSM is in IDLE. It first rises on the first clock edge after `rst_n` deasserts.
- Latency with a zero-wait target, counting cycle N as acceptance:
  - `tX_valid` is high in N+1.
  - `resp_valid` is high in N+2.
  - The next request can be accepted in N+3.
- Decode miss: `resp_valid` with `resp_err` is high in N+1.
- Throughput: at most one transaction per 3 cycles.
- `rst_n` asserted mid-transaction: all outputs return to their reset values immediately (asynchronously). The in-flight transaction is dropped, and no `resp_valid` is issued for it.

## Configuration
- `DMEM_DEMUX_TIMEOUT_EN` defined:
  - An 8-bit watchdog clears on entry to REQ and increments every cycle spent in REQ or WAIT.
  - When it reaches `TIMEOUT`, the FSM goes to RESP with `resp_err=1` and `resp_rdata=0`, and drops `tX_valid`.
  - A `tX_ready` or `tX_rvalid` arriving in the same cycle as the timeout wins: the transaction completes normally.
  - A late `rvalid` that arrives after the timeout is ignored.
- `DMEM_DEMUX_TIMEOUT_EN` not defined: no watchdog logic is built. REQ and WAIT wait indefinitely, and `resp_err` comes only from decode misses.

## Test plan
- Store of 0xDEADBEEF to address 0x0000_0010 with `be`=4'hF, port 0 with `ready` tied to 1 -> `t0_valid` for one cycle with those values, `resp_valid` 2 cycles after acceptance, `resp_err=0`, and `t1_valid` never rises.
- Load from 0x1000_0004, with `t1_ready` arriving after 3 cycles and `t1_rvalid` with 0x12345678 arriving 2 cycles later -> fields held stable while `t1_valid` is high, then `resp_valid` with `resp_rdata=0x12345678`.
- Load from 0x2000_0000 (decode miss) -> `resp_valid` and `resp_err=1` in N+1, `rdata=0`, and no `tX_valid` on either port.
- Back-to-back `req_valid` held high for 4 loads to port 0 with a zero-wait target -> acceptances at cycles 0, 3, 6, 9, with the responses in order and correct.
- `rst_n` pulsed low while in WAIT -> all outputs 0 asynchronously, no `resp_valid` afterwards, and `req_ready=1` one edge after release.
- With `DMEM_DEMUX_TIMEOUT_EN` and `TIMEOUT`=8, `t0_ready` held at 0 -> `resp_err=1` on the 9th cycle after acceptance, and a later `t0_rvalid` is ignored.
